// File: rtl/cm_sync_generator.sv
// Line/frame timing generator: Sync framing, porch-bounded data-enable,
// pixel/line coordinates and frame markers for test-pattern sources.
module cm_sync_generator #(
  parameter int BP_W = 8,
  parameter int FP_W = 12,
  parameter int LN_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Enable,
  input  logic [BP_W-1:0] BackPorch,
  input  logic [FP_W-1:0] FrontPorch,
  input  logic [FP_W-1:0] LineLength,
  input  logic [BP_W-1:0] BlankLength,
  input  logic [LN_W-1:0] LinesPerFrame,
  output logic            Sync,
  output logic            DataEnable,
  output logic [FP_W-1:0] PixelX,
  output logic [LN_W-1:0] PixelY,
  output logic            LineStart,
  output logic            FrameStart,
  output logic            Busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_LINE  = 2'd2;

  logic [1:0]      state, nstate;
  logic [BP_W-1:0] bcnt, nbcnt, bmax;
  logic [FP_W-1:0] k, nk;
  logic [LN_W-1:0] line, nline, lpf_m1;
  logic [FP_W-1:0] sh_bp, sh_fp, sh_len;
  logic [FP_W-1:0] n_bp, n_fp, n_len;
  logic [LN_W-1:0] sh_lpf, n_lpf;
  logic            n_de, n_ls;

  // Zero blank still yields one low Sync cycle; zero lines/frame acts as one.
  assign bmax = (BlankLength == '0) ? '0
              : BlankLength - BP_W'(1);
  assign lpf_m1 = (sh_lpf == '0) ? '0
                : sh_lpf - LN_W'(1);

  always_comb begin
    nstate = state;
    nbcnt  = bcnt;
    nk     = k;
    nline  = line;
    n_bp   = sh_bp;
    n_fp   = sh_fp;
    n_len  = sh_len;
    n_lpf  = sh_lpf;
    unique case (1'b1)
      state == S_IDLE: begin
        nbcnt = '0;
        nk    = '0;
        nline = '0;
        if (Enable) nstate = S_BLANK;
      end
      state == S_BLANK: begin
        nk = '0;
        if (bcnt == bmax) begin
          nbcnt = '0;
          if (LineLength == '0) begin
            nstate = S_BLANK;
          end else if (!Enable && line == '0) begin
            nstate = S_IDLE;
          end else begin
            nstate = S_LINE;
            n_bp   = FP_W'(BackPorch);
            n_fp   = FrontPorch;
            n_len  = LineLength;
            n_lpf  = LinesPerFrame;
          end
        end else begin
          nbcnt = bcnt + BP_W'(1);
        end
      end
      state == S_LINE: begin
        if (k == sh_len - FP_W'(1)) begin
          nstate = S_BLANK;
          nk     = '0;
          nline  = (line == lpf_m1) ? '0
                 : line + LN_W'(1);
        end else begin
          nk = k + FP_W'(1);
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  assign n_de = (nstate == S_LINE)
              && (nk > n_bp) && (nk < n_fp);
  assign n_ls = (nstate == S_LINE)
              && (state != S_LINE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bcnt       <= '0;
      k          <= '0;
      line       <= '0;
      sh_bp      <= '0;
      sh_fp      <= '0;
      sh_len     <= '0;
      sh_lpf     <= '0;
      Sync       <= 1'b0;
      DataEnable <= 1'b0;
      PixelX     <= '0;
      PixelY     <= '0;
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state      <= nstate;
      bcnt       <= nbcnt;
      k          <= nk;
      line       <= nline;
      sh_bp      <= n_bp;
      sh_fp      <= n_fp;
      sh_len     <= n_len;
      sh_lpf     <= n_lpf;
      Sync       <= (nstate == S_LINE);
      DataEnable <= n_de;
      PixelX     <= n_de ? nk - n_bp - FP_W'(1) : '0;
      PixelY     <= nline;
      LineStart  <= n_ls;
      FrameStart <= n_ls && (nline == '0);
      Busy       <= (nstate != S_IDLE);
    end
  end

endmodule

// File: tb/tb_cm_sync_generator.sv
// Scoreboard bench for cm_sync_generator: per-line records predicted
// from line configuration, checked by an independent line monitor.
module tb_cm_sync_generator;

  localparam int BP_W = 8;
  localparam int FP_W = 12;
  localparam int LN_W = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            Enable;
  logic [BP_W-1:0] BackPorch;
  logic [FP_W-1:0] FrontPorch;
  logic [FP_W-1:0] LineLength;
  logic [BP_W-1:0] BlankLength;
  logic [LN_W-1:0] LinesPerFrame;
  logic            Sync, DataEnable, LineStart, FrameStart, Busy;
  logic [FP_W-1:0] PixelX;
  logic [LN_W-1:0] PixelY;

  cm_sync_generator #(
    .BP_W(BP_W), .FP_W(FP_W), .LN_W(LN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Enable(Enable),
    .BackPorch(BackPorch), .FrontPorch(FrontPorch),
    .LineLength(LineLength), .BlankLength(BlankLength),
    .LinesPerFrame(LinesPerFrame),
    .Sync(Sync), .DataEnable(DataEnable),
    .PixelX(PixelX), .PixelY(PixelY),
    .LineStart(LineStart), .FrameStart(FrameStart),
    .Busy(Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len; int blank; int de_first;
    int de_cnt; int y; int fs;
  } rec_t;

  rec_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  int c_bp, c_fp, c_len, c_bl, c_lpf;
  int m_y, last_y;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: rebuilds one record per Sync-high line
  bit in_line = 0;
  int blank_cnt = 0;
  int a_k, a_blank, a_fs, a_y, a_def, a_dec;
  int a_pxbad, a_ybad;
  rec_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_line   = 0;
      blank_cnt = 0;
    end else begin
      if (in_line && !Sync) begin
        in_line = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_line", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("line_len", a_k, e.len);
          chk("blank_len", a_blank, e.blank);
          chk("de_first_k", a_def, e.de_first);
          chk("de_count", a_dec, e.de_cnt);
          chk("pixel_y", a_y, e.y);
          chk("frame_start", a_fs, e.fs);
          chk("pixel_x_seq_err", a_pxbad, 0);
          chk("pixel_y_unstable", a_ybad, 0);
        end
      end
      if (Sync) begin
        if (LineStart) begin
          in_line = 1;
          a_k = 0; a_blank = blank_cnt;
          blank_cnt = 0;
          a_fs = 0; a_y = int'(PixelY);
          a_def = -1; a_dec = 0;
          a_pxbad = 0; a_ybad = 0;
        end
        if (in_line) begin
          if (FrameStart) a_fs++;
          if (int'(PixelY) != a_y) a_ybad = 1;
          if (DataEnable) begin
            if (a_def < 0) a_def = a_k;
            if (int'(PixelX) != a_dec) a_pxbad = 1;
            a_dec++;
          end else if (PixelX != '0) begin
            a_pxbad = 1;
          end
          a_k++;
        end
      end else if (Busy) begin
        blank_cnt++;
      end
      if (!Busy) blank_cnt = 0;
    end
  end

  task automatic set_cfg(int bp, int fp, int len, int bl, int lpf);
    c_bp = bp; c_fp = fp; c_len = len;
    c_bl = bl; c_lpf = lpf;
    BackPorch     = BP_W'(bp);
    FrontPorch    = FP_W'(fp);
    LineLength    = FP_W'(len);
    BlankLength   = BP_W'(bl);
    LinesPerFrame = LN_W'(lpf);
  endtask

  // Reference: what the next line must look like under current config
  task automatic push_line();
    rec_t r;
    int w, hi, lines;
    hi = (c_fp < c_len) ? c_fp : c_len;
    w  = hi - c_bp - 1;
    r.len      = c_len;
    r.blank    = (c_bl == 0) ? 1 : c_bl;
    r.de_cnt   = (w > 0) ? w : 0;
    r.de_first = (r.de_cnt > 0) ? c_bp + 1 : -1;
    r.y        = m_y;
    r.fs       = (m_y == 0) ? 1 : 0;
    exp_q.push_back(r);
    last_y = m_y;
    lines  = (c_lpf == 0) ? 1 : c_lpf;
    m_y    = (m_y + 1 >= lines) ? 0 : m_y + 1;
  endtask

  task automatic next_line();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (LineStart) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("line_start_timeout", 0, 1);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_sync"}, int'(Sync), 0);
    chk({tag, "_de"}, int'(DataEnable), 0);
    chk({tag, "_px"}, int'(PixelX), 0);
    chk({tag, "_py"}, int'(PixelY), 0);
    chk({tag, "_ls"}, int'(LineStart), 0);
    chk({tag, "_fs"}, int'(FrameStart), 0);
    chk({tag, "_busy"}, int'(Busy), 0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      n++;
      if (!Busy) break;
    end
    chk("idle_reached", int'(Busy), 0);
  endtask

  int tbl [6][4] = '{
    '{2, 7, 10, 0}, '{2, 3, 10, 3},
    '{2, 20, 10, 1}, '{5, 7, 10, 3},
    '{0, 1, 12, 2}, '{3, 4, 6, 0}
  };

  initial begin
    int n;
    rst_n  = 1'b0;
    Enable = 1'b0;
    m_y    = 0;
    last_y = 0;
    set_cfg(2, 7, 10, 3, 2);
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) chk("idle_busy", int'(Busy), 0);

    Enable = 1'b1;
    push_line();
    @(negedge clk);
    chk("start_busy", int'(Busy), 1);
    chk("start_sync", int'(Sync), 0);

    repeat (5) begin
      next_line();
      push_line();
    end

    // Edge configs, including a mid-line backporch change
    for (int i = 0; i < 6; i++) begin
      next_line();
      set_cfg(tbl[i][0], tbl[i][1], tbl[i][2],
              tbl[i][3], c_lpf);
      push_line();
    end

    repeat (30) begin
      next_line();
      set_cfg($urandom_range(12, 0), $urandom_range(25, 0),
              $urandom_range(20, 1), $urandom_range(5, 0),
              (m_y == 0) ? $urandom_range(3, 0) : c_lpf);
      push_line();
    end

    // Drop Enable during line 1 of a 3-line frame
    for (int i = 0; i < 20; i++) begin
      next_line();
      if (c_lpf == 3 && last_y == 1) Enable = 1'b0;
      set_cfg(2, 7, 10, 3, (m_y == 0) ? 3 : c_lpf);
      if (!Enable && m_y == 0) break;
      push_line();
    end
    chk("drop_enable_seen", int'(Enable), 0);
    wait_idle(n);
    chk("last_line_to_idle", n, 13);
    repeat (5) begin
      @(negedge clk);
      chk("idle_hold", int'(Busy | Sync), 0);
    end
    chk("drop_queue_empty", exp_q.size(), 0);

    // Reset at k=4 of line 1
    m_y = 0;
    Enable = 1'b1;
    push_line();
    for (int i = 0; i < 10; i++) begin
      next_line();
      if (last_y == 1) break;
      push_line();
    end
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    exp_q.delete();
    m_y = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_line();
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (FrameStart) break;
    end
    chk("restart_fs_delay", n, 4);
    chk("restart_py", int'(PixelY), 0);

    Enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_line();
      if (!Enable && m_y == 0) break;
      push_line();
    end
    wait_idle(n);
    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
